// File: rtl/line_buffer_3row.sv
// Four-bank row buffer feeding a 3x3 convolution window: three banks are read
// column by column while the fourth fills from a valid/ready raster stream.
module line_buffer_3row #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_WIDTH = 8,
  parameter int COL_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_DEPTH-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic                 shift,
  output logic [BIT_DEPTH-1:0] out_l1,
  output logic [BIT_DEPTH-1:0] out_l2,
  output logic [BIT_DEPTH-1:0] out_l3,
  output logic                 out_valid,
  output logic                 rows_ready,
  output logic                 row_done
);

  // Handshake: a pixel transfers on any rising clk where pix_valid & pix_ready;
  // pix_ready never looks at pix_valid, and shift is a request with no back-pressure.

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  logic [BIT_DEPTH-1:0] bank_q [0:3][0:IMG_WIDTH-1];

  logic [COL_W-1:0]     wr_col_q, wr_col_d;
  logic [1:0]           wr_bank_q, wr_bank_d;
  logic [COL_W-1:0]     rd_col_q, rd_col_d;
  logic [1:0]           top_bank_q, top_bank_d;
  logic [2:0]           full_rows_q, full_rows_d;
  logic [BIT_DEPTH-1:0] out_l1_q, out_l1_d;
  logic [BIT_DEPTH-1:0] out_l2_q, out_l2_d;
  logic [BIT_DEPTH-1:0] out_l3_q, out_l3_d;
  logic                 out_valid_q, out_valid_d;
  logic                 row_done_q, row_done_d;

  logic wr_fire, rd_fire, row_complete, row_consumed;
  logic [1:0] mid_bank, bot_bank;

  assign pix_ready    = (full_rows_q < 3'd4) & ~rst;
  assign rows_ready   = (full_rows_q >= 3'd3);
  assign wr_fire      = pix_valid & pix_ready;
  assign rd_fire      = shift & rows_ready;
  assign row_complete = wr_fire & (wr_col_q == LAST_COL);
  assign row_consumed = rd_fire & (rd_col_q == LAST_COL);
  assign mid_bank     = top_bank_q + 2'd1;
  assign bot_bank     = top_bank_q + 2'd2;

  always_comb begin
    wr_col_d    = wr_col_q;
    wr_bank_d   = wr_bank_q;
    rd_col_d    = rd_col_q;
    top_bank_d  = top_bank_q;
    full_rows_d = full_rows_q;
    out_l1_d    = out_l1_q;
    out_l2_d    = out_l2_q;
    out_l3_d    = out_l3_q;
    out_valid_d = 1'b0;
    row_done_d  = 1'b0;

    if (wr_fire) begin
      if (row_complete) begin
        wr_col_d  = '0;
        wr_bank_d = wr_bank_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end

    if (rd_fire) begin
      out_l1_d    = bank_q[top_bank_q][rd_col_q];
      out_l2_d    = bank_q[mid_bank][rd_col_q];
      out_l3_d    = bank_q[bot_bank][rd_col_q];
      out_valid_d = 1'b1;
      if (row_consumed) begin
        rd_col_d   = '0;
        top_bank_d = top_bank_q + 2'd1;
        row_done_d = 1'b1;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end

    // A row finishing and a row draining in the same cycle cancel out.
    if (row_complete && !row_consumed) begin
      full_rows_d = full_rows_q + 3'd1;
    end else if (row_consumed && !row_complete) begin
      full_rows_d = full_rows_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col_q    <= '0;
      wr_bank_q   <= '0;
      rd_col_q    <= '0;
      top_bank_q  <= '0;
      full_rows_q <= '0;
      out_l1_q    <= '0;
      out_l2_q    <= '0;
      out_l3_q    <= '0;
      out_valid_q <= 1'b0;
      row_done_q  <= 1'b0;
    end else begin
      wr_col_q    <= wr_col_d;
      wr_bank_q   <= wr_bank_d;
      rd_col_q    <= rd_col_d;
      top_bank_q  <= top_bank_d;
      full_rows_q <= full_rows_d;
      out_l1_q    <= out_l1_d;
      out_l2_q    <= out_l2_d;
      out_l3_q    <= out_l3_d;
      out_valid_q <= out_valid_d;
      row_done_q  <= row_done_d;
    end
  end

  // Bank contents survive reset; wr_fire is already low while rst is high.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_q[wr_bank_q][wr_col_q] <= pix_in;
    end
  end

  assign out_l1    = out_l1_q;
  assign out_l2    = out_l2_q;
  assign out_l3    = out_l3_q;
  assign out_valid = out_valid_q;
  assign row_done  = row_done_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed + random bench for line_buffer_3row, checked against a model that
// keeps the accepted pixel history and counts whole rows written and consumed.
module tb_line_buffer_3row;

  localparam int BD = 8;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BD-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          shift = 1'b0;
  logic          pix_ready, rows_ready, out_valid, row_done;
  logic [BD-1:0] out_l1, out_l2, out_l3;

  line_buffer_3row #(.BIT_DEPTH(BD), .IMG_WIDTH(W), .COL_W(CW)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .shift(shift), .out_l1(out_l1), .out_l2(out_l2),
    .out_l3(out_l3), .out_valid(out_valid), .rows_ready(rows_ready),
    .row_done(row_done)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted pixel since reset, in raster order.
  logic [BD-1:0] exp_q[$];
  int            cons_rows = 0;
  int            m_rd_col  = 0;
  logic [BD-1:0] e_l1 = '0, e_l2 = '0, e_l3 = '0;
  logic          e_valid = 1'b0, e_done = 1'b0;
  logic          last_acc = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int full_rows_m();
    return exp_q.size() / W - cons_rows;
  endfunction

  // One clock: drive inputs, check combinational flags, step model, check registers.
  task automatic cycle(input logic r, input logic v, input logic [BD-1:0] p, input logic s);
    logic m_ready, m_rows, wfire, rfire;
    rst = r; pix_valid = v; pix_in = p; shift = s;
    #1;
    m_ready = (full_rows_m() < 4) && !r;
    m_rows  = (full_rows_m() >= 3);
    chk("pix_ready", {31'd0, pix_ready}, {31'd0, m_ready});
    chk("rows_ready", {31'd0, rows_ready}, {31'd0, m_rows});
    wfire = v && m_ready;
    rfire = s && m_rows && !r;
    @(posedge clk);
    #1;
    last_acc = wfire;
    if (r) begin
      exp_q.delete();
      cons_rows = 0; m_rd_col = 0;
      e_l1 = '0; e_l2 = '0; e_l3 = '0; e_valid = 1'b0; e_done = 1'b0;
    end else begin
      e_valid = rfire;
      e_done  = 1'b0;
      if (rfire) begin
        e_l1 = exp_q[cons_rows * W + m_rd_col];
        e_l2 = exp_q[(cons_rows + 1) * W + m_rd_col];
        e_l3 = exp_q[(cons_rows + 2) * W + m_rd_col];
        if (m_rd_col == W - 1) begin
          e_done = 1'b1; m_rd_col = 0; cons_rows++;
        end else begin
          m_rd_col++;
        end
      end
      if (wfire) exp_q.push_back(p);
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    chk("row_done", {31'd0, row_done}, {31'd0, e_done});
    chk("out_l1", {24'd0, out_l1}, {24'd0, e_l1});
    chk("out_l2", {24'd0, out_l2}, {24'd0, e_l2});
    chk("out_l3", {24'd0, out_l3}, {24'd0, e_l3});
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic push_px(input logic [BD-1:0] p);
    int guard = 0;
    do begin
      cycle(1'b0, 1'b1, p, 1'b0);
      guard++;
    end while (!last_acc && guard < 20);
    chk("push_accept", {31'd0, last_acc}, 32'd1);
  endtask

  task automatic do_shifts(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("rst_out_l1", {24'd0, out_l1}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // Fill and read
    for (int i = 1; i <= 12; i++) push_px(BD'(i));
    cycle(1'b0, 1'b0, '0, 1'b0);
    chk("fill_rows_ready", {31'd0, rows_ready}, 32'd1);
    do_shifts(1);
    chk("fill_col0", {8'd0, out_l1, out_l2, out_l3}, 32'h00010509);
    do_shifts(3);
    chk("fill_col3", {8'd0, out_l1, out_l2, out_l3}, 32'h0004080C);
    chk("fill_row_done", {31'd0, row_done}, 32'd1);

    // Stall on full
    do_reset();
    for (int i = 1; i <= 16; i++) push_px(BD'(i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'd17, 1'b0);
    chk("stall_ready_low", {31'd0, pix_ready}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'd17, 1'b1);
    cycle(1'b0, 1'b1, 8'd17, 1'b0);
    chk("stall_17_accepted", {31'd0, last_acc}, 32'd1);
    for (int i = 18; i <= 20; i++) push_px(BD'(i));
    do_shifts(1);
    chk("stall_col0", {8'd0, out_l1, out_l2, out_l3}, 32'h0005090D);
    do_shifts(3);
    chk("stall_col3", {8'd0, out_l1, out_l2, out_l3}, 32'h00080C10);

    // Early shift
    do_reset();
    for (int i = 1; i <= 8; i++) push_px(BD'(i));
    do_shifts(3);
    chk("early_valid", {31'd0, out_valid}, 32'd0);
    chk("early_l1", {24'd0, out_l1}, 32'd0);
    for (int i = 9; i <= 12; i++) push_px(BD'(i));
    do_shifts(1);
    chk("early_col0", {8'd0, out_l1, out_l2, out_l3}, 32'h00010509);

    // Simultaneous row complete and row consume
    do_reset();
    for (int i = 1; i <= 12; i++) push_px(BD'(i));
    for (int i = 13; i <= 16; i++) cycle(1'b0, 1'b1, BD'(i), 1'b1);
    chk("sim_row_done", {31'd0, row_done}, 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    chk("sim_rows_ready", {31'd0, rows_ready}, 32'd1);
    do_shifts(1);
    chk("sim_col0", {8'd0, out_l1, out_l2, out_l3}, 32'h0005090D);

    // Mid-operation reset after 6 shifts
    do_shifts(5);
    cycle(1'b1, 1'b1, 8'h55, 1'b1);
    chk("mrst_l3", {24'd0, out_l3}, 32'd0);
    for (int i = 101; i <= 112; i++) push_px(BD'(i));
    do_shifts(1);
    chk("mrst_col0", {8'd0, out_l1, out_l2, out_l3}, {8'd0, 8'd101, 8'd105, 8'd109});

    // Back-to-back with random pixels
    do_reset();
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, BD'($urandom_range(0, 255)), 1'b1);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            BD'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
